// File: rtl/gray_dir_decoder.sv
// Recovers step direction and position from a 2-bit Gray up/down sequence,
// with input synchronization, post-reset arming, idle timeout and error latch.
module gray_dir_decoder #(
  parameter int WIDTH      = 8,
  parameter int IDLE_LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic             step_pulse,
  output logic             dir_out,
  output logic             moving,
  output logic [WIDTH-1:0] pos,
  output logic             err
);

  localparam int IW = (IDLE_LIMIT < 2) ? 1 : $clog2(IDLE_LIMIT);

  typedef enum logic [1:0] {IDLE, UP, DOWN, ERR} state_t;
  typedef enum logic [1:0] {NONE, STEP_UP, STEP_DN, JUMP} step_t;

  function automatic step_t classify(input logic [1:0] prv, input logic [1:0] cur);
    step_t s;
    s = NONE;
    case ({prv, cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: s = STEP_UP;
      4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: s = STEP_DN;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: s = JUMP;
      default:                                s = NONE;
    endcase
    return s;
  endfunction

  logic [1:0]       ab_p0;
  logic [1:0]       ab_p1;
  logic [1:0]       prev_p2;
  logic [1:0]       arm;
  state_t           state;
  state_t           state_nx;
  logic [IW-1:0]    idle_cnt;
  logic [IW-1:0]    idle_nx;
  logic [WIDTH-1:0] pos_nx;
  logic             dir_nx;
  logic             pulse_nx;
  step_t            step;

  // Stage p1 -> p2: decode only once the synchronizer and prev hold post-reset samples
  assign step = (arm == 2'd3) ? classify(prev_p2, ab_p1) : NONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ab_p0      <= '0;
      ab_p1      <= '0;
      prev_p2    <= '0;
      arm        <= '0;
      state      <= IDLE;
      idle_cnt   <= '0;
      pos        <= '0;
      dir_out    <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      ab_p0      <= {a_in, b_in};
      ab_p1      <= ab_p0;
      prev_p2    <= ab_p1;
      if (arm != 2'd3) arm <= arm + 2'd1;
      state      <= state_nx;
      idle_cnt   <= idle_nx;
      pos        <= pos_nx;
      dir_out    <= dir_nx;
      step_pulse <= pulse_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idle_nx  = idle_cnt;
    pos_nx   = pos;
    dir_nx   = dir_out;
    pulse_nx = 1'b0;
    if (state == ERR) begin
      // clr takes priority; any step decoded in the same cycle is dropped
      if (clr) begin
        state_nx = IDLE;
        idle_nx  = '0;
      end
    end else begin
      case (step)
        STEP_UP: begin
          state_nx = UP;
          idle_nx  = '0;
          pos_nx   = pos + WIDTH'(1);
          dir_nx   = 1'b1;
          pulse_nx = 1'b1;
        end
        STEP_DN: begin
          state_nx = DOWN;
          idle_nx  = '0;
          pos_nx   = pos - WIDTH'(1);
          dir_nx   = 1'b0;
          pulse_nx = 1'b1;
        end
        JUMP: begin
          state_nx = ERR;
          idle_nx  = '0;
        end
        default: begin
          if (state != IDLE) begin
            if (idle_cnt == IW'(IDLE_LIMIT - 1)) begin
              state_nx = IDLE;
              idle_nx  = '0;
            end else begin
              idle_nx = idle_cnt + IW'(1);
            end
          end
        end
      endcase
    end
  end

  assign moving = (state == UP) || (state == DOWN);
  assign err    = (state == ERR);

endmodule

// File: tb/tb_gray_dir_decoder.sv
// Bench for gray_dir_decoder: directed scenarios plus a random Gray walk, all
// compared every cycle against a history-based reference model.
module tb_gray_dir_decoder;
  localparam int WIDTH      = 8;
  localparam int IDLE_LIMIT = 15;
  localparam int MODV       = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             a_in = 1'b0;
  logic             b_in = 1'b0;
  logic             clr = 1'b0;
  logic             step_pulse;
  logic             dir_out;
  logic             moving;
  logic [WIDTH-1:0] pos;
  logic             err;

  int n_cmp = 0;
  int n_bad = 0;
  int dut_pulses = 0;

  // Reference model: raw input history since reset release plus abstract status
  int hist[$];
  int edges;
  int m_pos;
  bit m_dir, m_pulse, m_err, m_active;
  int m_last;

  logic [1:0] gb [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  always #5 clk = ~clk;

  gray_dir_decoder #(.WIDTH(WIDTH), .IDLE_LIMIT(IDLE_LIMIT)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .clr(clr),
    .step_pulse(step_pulse), .dir_out(dir_out), .moving(moving),
    .pos(pos), .err(err)
  );

  // Position of a code along the up-counting Gray cycle 00,01,11,10
  function automatic int gidx(input int v);
    case (v)
      0: return 0;
      1: return 1;
      3: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    edges    = 0;
    m_pos    = 0;
    m_dir    = 0;
    m_pulse  = 0;
    m_err    = 0;
    m_active = 0;
    m_last   = 0;
  endtask

  task automatic model_edge();
    int cls;
    int n;
    edges++;
    hist.push_back(int'({a_in, b_in}));
    if (hist.size() > 8) void'(hist.pop_front());
    m_pulse = 0;
    cls = 0;
    n = hist.size();
    // A change sampled at edge k is judged at edge k+2 against the sample before it
    if (edges >= 4) cls = (gidx(hist[n-3]) - gidx(hist[n-4])) & 3;
    if (m_err) begin
      if (clr) begin
        m_err    = 0;
        m_active = 0;
      end
    end else begin
      case (cls)
        1: begin
          m_pos = (m_pos + 1) % MODV;
          m_dir = 1; m_pulse = 1; m_active = 1; m_last = edges;
        end
        3: begin
          m_pos = (m_pos + MODV - 1) % MODV;
          m_dir = 0; m_pulse = 1; m_active = 1; m_last = edges;
        end
        2: begin
          m_err    = 1;
          m_active = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    bit exp_moving;
    exp_moving = m_active && ((edges - m_last) < IDLE_LIMIT);
    if (step_pulse === 1'b1) dut_pulses++;
    check("step_pulse", step_pulse, m_pulse);
    check("dir_out", dir_out, m_dir);
    check("pos", pos, m_pos);
    check("moving", moving, exp_moving);
    check("err", err, m_err);
  endtask

  // Called at a falling edge; drives inputs, steps the model at the rising edge,
  // compares at the next falling edge.
  task automatic cycle(input logic a, input logic b, input logic c);
    a_in = a;
    b_in = b;
    clr  = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input logic a, input logic b);
    reset = 1'b1;
    a_in  = a;
    b_in  = b;
    clr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pos", pos, 0);
    check("rst_err", err, 0);
    check("rst_moving", moving, 0);
    check("rst_pulse", step_pulse, 0);
    check("rst_dir", dir_out, 0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int p0;
    int g;
    int r;
    logic [1:0] v;
    logic c;

    model_reset();

    // Non-zero input at release must not raise err
    do_reset(1'b1, 1'b1);
    repeat (10) cycle(1'b1, 1'b1, 1'b0);
    check("idle11_err", err, 0);
    check("idle11_pos", pos, 0);
    check("idle11_moving", moving, 0);

    // Four up steps, each pulse three edges after its input change
    do_reset(1'b0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    p0 = dut_pulses;
    for (int s = 1; s <= 4; s++) begin
      v = gb[s % 4];
      for (int k = 0; k < 4; k++) begin
        cycle(v[1], v[0], 1'b0);
        check("up_pulse_timing", step_pulse, (k == 2) ? 1 : 0);
      end
    end
    check("up_pulse_count", dut_pulses - p0, 4);
    check("up_pos", pos, 4);
    check("up_dir", dir_out, 1);
    check("up_moving", moving, 1);

    // Down step from zero wraps, then idle timeout keeps direction
    do_reset(1'b0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    check("down_pos_wrap", pos, 255);
    check("down_dir", dir_out, 0);
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      check("timeout_moving", moving, (i < IDLE_LIMIT) ? 1 : 0);
    end
    check("timeout_dir", dir_out, 0);
    check("timeout_pos", pos, 255);

    // Up step back to zero, then illegal jump 00->11
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    check("wrap_up_pos", pos, 0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    check("jump_err", err, 1);
    check("jump_pos", pos, 0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    check("err_ignore_pos", pos, 0);
    check("err_ignore_err", err, 1);
    cycle(1'b0, 1'b0, 1'b1);
    check("clr_err", err, 0);
    check("clr_moving", moving, 0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    check("after_clr_pos", pos, 1);

    // clr on the same edge a step decodes in ERR: step is discarded
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    check("jump2_err", err, 1);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("clr_vs_step_pulse", step_pulse, 0);
    check("clr_vs_step_pos", pos, 1);
    check("clr_vs_step_err", err, 0);
    check("clr_vs_step_moving", moving, 0);

    // Random Gray walk with occasional jumps and clr pulses
    g = 0;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 19);
      if (r < 10)      g = g;
      else if (r < 14) g = (g + 1) % 4;
      else if (r < 18) g = (g + 3) % 4;
      else             g = (g + 2) % 4;
      c = ($urandom_range(0, 7) == 0);
      v = gb[g];
      cycle(v[1], v[0], c);
    end

    // Asynchronous reset between edges while moving up at pos=7
    do_reset(1'b0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    for (int s = 1; s <= 7; s++) begin
      v = gb[s % 4];
      repeat (2) cycle(v[1], v[0], 1'b0);
    end
    repeat (2) cycle(v[1], v[0], 1'b0);
    check("pre_async_pos", pos, 7);
    check("pre_async_moving", moving, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_pos", pos, 0);
    check("async_rst_moving", moving, 0);
    check("async_rst_pulse", step_pulse, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (6) cycle(v[1], v[0], 1'b0);
    check("rearm_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_dir_decoder.md
GRAY_DIR_DECODER -- requirements
Module: gray_dir_decoder

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the width of the position counter pos.
REQ-002 Parameter IDLE_LIMIT, default 15, SHALL set the number of clock cycles without a valid step before motion is declared stopped.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 a_in  input  1  SHALL be Gray-state bit A from the up/down Gray sequencer, asynchronous to clk.
REQ-006 b_in  input  1  SHALL be Gray-state bit B from the up/down Gray sequencer, asynchronous to clk.
REQ-007 clr  input  1  SHALL clear the error state.
REQ-008 step_pulse  output  1  SHALL be high for one cycle per accepted step.
REQ-009 dir_out  output  1  SHALL indicate direction: 1 = up (recovered x=1), 0 = down (recovered x=0).
REQ-010 moving  output  1  SHALL be high while the FSM is in UP or DOWN.
REQ-011 pos  output  WIDTH  SHALL be the signed-agnostic step count, wrapping modulo 2^WIDTH.
REQ-012 err  output  1  SHALL be high while the FSM is in ERR.

Function
REQ-013 a_in and b_in SHALL each pass through a 2-flop synchronizer; only the stage-2 value {A,B} SHALL be decoded.
REQ-014 A prev register SHALL hold the previous stage-2 value and SHALL load stage-2 every cycle.
REQ-015 Decode SHALL be disabled until an arm counter (0..3) reaches 3 after reset release; while disabled, no step, error or position change SHALL occur.
REQ-016 Up steps: 00->01, 01->11, 11->10, 10->00; down steps: the reverse of each.
REQ-017 No change in {A,B} SHALL be no step; a change of both bits SHALL be an illegal jump.
REQ-018 FSM states: IDLE, UP, DOWN, ERR; reset state IDLE.
REQ-019 In IDLE, UP or DOWN: an up step SHALL go to UP, a down step to DOWN, and an illegal jump to ERR.
REQ-020 In UP or DOWN: IDLE_LIMIT consecutive cycles without a step SHALL go to IDLE; the idle counter SHALL reset on every step.
REQ-021 In ERR: steps and jumps SHALL be ignored and pos frozen; clr SHALL go to IDLE.
REQ-022 clr asserted in a cycle with a decoded step: clr wins, and the step SHALL be discarded (no pulse, no pos change).
REQ-023 clr outside ERR SHALL have no effect.
REQ-024 On an accepted up step, pos SHALL increment by 1 (all-ones wraps to 0); on an accepted down step, pos SHALL decrement by 1 (0 wraps to all-ones).
REQ-025 step_pulse, dir_out and pos SHALL be registered and update on the same edge.
REQ-026 Latency: an input change first sampled at edge n SHALL produce step_pulse, pos and dir_out updates visible after edge n+2.
REQ-027 In IDLE, dir_out SHALL hold its last value.
REQ-028 An illegal jump SHALL not change pos or dir_out.

Reset
REQ-029 While reset is high: synchronizers, prev and arm counter SHALL be 0; state SHALL be IDLE; step_pulse=0, dir_out=0, moving=0, pos=0, err=0.
REQ-030 Reset asserted mid-operation SHALL clear all state immediately, without waiting for clk.
REQ-031 After reset deasserts, the block SHALL re-arm per REQ-015, so a non-00 input at release SHALL NOT raise err.

Verification
REQ-032 Reset, then hold {a,b}=11 for 10 cycles -> err=0, pos=0, moving=0.
REQ-033 After arming, step 00->01->11->10->00 every 4 cycles -> 4 step_pulses, pos=4, dir_out=1, moving=1; each pulse appears 3 edges after its input change.
REQ-034 From pos=0, one down step 00->10 -> pos=255 (WIDTH=8), dir_out=0; then 20 cycles with no step -> moving=0 after 15 cycles, dir_out stays 0.
REQ-035 Jump 00->11 -> err=1 and pos unchanged; further steps are ignored; clr -> IDLE, err=0; next valid up step -> pos+1.
REQ-036 Assert clr on the same edge a step decodes while in ERR -> no step_pulse, pos unchanged, state IDLE.
REQ-037 Assert reset asynchronously between edges while pos=7 and in UP -> pos=0, moving=0 immediately.
